// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// sequencer state encoding and the natural-alignment check.
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // True when the byte offset is naturally aligned for the access size.
    // The reserved size 2'b11 is never aligned, so it always decodes as an error.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~offset[0];
            SIZE_WORD: ok = (offset == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Bundles the controller request/response handshake and the data-memory
// strobes of the load/store unit.
//   slave  : the load/store unit itself (takes requests, drives mem_*).
//   master : the environment (controller + data memory).
// Signals:
//   req_valid/req_ready/req_write/req_size/req_unsigned/req_address/req_wdata
//   resp_valid/resp_rdata/resp_error
//   mem_read/mem_write/mem_address/mem_wdata/mem_rdata
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_address;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_error;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_read, mem_write, mem_address, mem_wdata
    );

endinterface

// File: rtl/lsu_byte_lane.sv
// -----------------------------------------------------------------------------
// lsu_byte_lane
// Combinational big-endian lane logic for sub-word accesses.
//   i_word     : 32-bit memory word (byte at offset 0 is bits 31:24)
//   i_size     : access size encoding
//   i_offset   : byte offset within the word
//   i_unsigned : 1 zero-extends, 0 sign-extends the extracted lane
//   i_wdata    : right-justified store data (byte or half)
//   o_load     : extracted, extended load data (whole word for word size)
//   o_merge    : i_word with only the addressed lane replaced by i_wdata
// -----------------------------------------------------------------------------
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];
    end

    always_comb begin
        o_load = i_word;
        case (i_size)
            SIZE_BYTE: o_load = i_unsigned ? {24'h000000, w_byte}
                                           : {{24{w_byte[7]}}, w_byte};
            SIZE_HALF: o_load = i_unsigned ? {16'h0000, w_half}
                                           : {{16{w_half[15]}}, w_half};
            default:   o_load = i_word;
        endcase
    end

    always_comb begin
        o_merge = i_word;
        case (i_size)
            SIZE_BYTE: begin
                case (i_offset)
                    2'd0:    o_merge[31:24] = i_wdata[7:0];
                    2'd1:    o_merge[23:16] = i_wdata[7:0];
                    2'd2:    o_merge[15:8]  = i_wdata[7:0];
                    default: o_merge[7:0]   = i_wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (i_offset[1]) begin
                    o_merge[15:0] = i_wdata;
                end else begin
                    o_merge[31:16] = i_wdata;
                end
            end
            default: o_merge = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator side of the CPU data-memory interface. Accepts one load/store
// request at a time, checks alignment/range/size, sequences the memory's
// read and write strobes and returns a one-cycle response pulse.
// Sub-word stores are done as read-modify-write because the memory only
// writes whole 32-bit words. All mem_* and resp_* outputs are registered on
// the rising edge so they are stable across the memory's negedge write.
//
// Parameters:
//   MEM_BYTES : memory size in bytes (word address must be <= MEM_BYTES-4)
//   ADDR_W    : address width
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load_store_unit_if.slave (request/response + memory strobes)
// Build option:
//   LSU_SUBWORD_EN : when defined, byte/half loads and read-modify-write
//                    byte/half stores are supported; otherwise only word
//                    accesses are legal and all other sizes complete as errors.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 32,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    load_store_unit_if.slave        bus
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

    lsu_state_t        r_state;
    logic              r_req_ready;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_address;
    logic [31:0]       r_mem_wdata;
    logic              r_resp_valid;
    logic              r_resp_error;
    logic [31:0]       r_resp_rdata;

    logic [ADDR_W-1:0] w_word_addr;
    logic              w_size_ok;
    logic              w_error;
    logic [31:0]       w_load_data;

`ifdef LSU_SUBWORD_EN
    logic              r_write;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [1:0]        r_offset;
    logic [15:0]       r_wdata;
    logic [31:0]       w_merge_data;

    lsu_byte_lane u_lane (
        .i_word     (bus.mem_rdata),
        .i_size     (r_size),
        .i_offset   (r_offset),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_load     (w_load_data),
        .o_merge    (w_merge_data)
    );

    assign w_size_ok = (bus.req_size != 2'b11);
`else
    logic w_unused_req_unsigned;

    assign w_load_data           = bus.mem_rdata;
    assign w_size_ok             = (bus.req_size == SIZE_WORD);
    assign w_unused_req_unsigned = bus.req_unsigned;
`endif

    assign w_word_addr = {bus.req_address[ADDR_W-1:2], 2'b00};
    assign w_error     = ~w_size_ok
                       | ~is_aligned(bus.req_size, bus.req_address[1:0])
                       | (w_word_addr > LAST_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_req_ready   <= 1'b1;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_error  <= 1'b0;
            r_resp_rdata  <= '0;
`ifdef LSU_SUBWORD_EN
            r_write       <= 1'b0;
            r_unsigned    <= 1'b0;
            r_size        <= '0;
            r_offset      <= '0;
            r_wdata       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_req_ready <= 1'b0;
`ifdef LSU_SUBWORD_EN
                        r_write     <= bus.req_write;
                        r_unsigned  <= bus.req_unsigned;
                        r_size      <= bus.req_size;
                        r_offset    <= bus.req_address[1:0];
                        r_wdata     <= bus.req_wdata[15:0];
`endif
                        if (w_error) begin
                            // Errors never touch memory.
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (bus.req_write && (bus.req_size == SIZE_WORD)) begin
                            r_state       <= WRITE;
                            r_mem_write   <= 1'b1;
                            r_mem_address <= w_word_addr;
                            r_mem_wdata   <= bus.req_wdata;
                        end else begin
                            // Loads, and the read half of a sub-word store.
                            r_state       <= READ;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= w_word_addr;
                        end
                    end
                end
                READ: begin
                    r_mem_read <= 1'b0;
`ifdef LSU_SUBWORD_EN
                    if (r_write) begin
                        r_state     <= WRITE;
                        r_mem_write <= 1'b1;
                        r_mem_wdata <= w_merge_data;
                    end else begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load_data;
                    end
`else
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
`endif
                end
                WRITE: begin
                    r_mem_write  <= 1'b0;
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_error <= 1'b0;
                    r_resp_rdata <= '0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_error  = r_resp_error;
    assign bus.resp_rdata  = r_resp_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Scoreboard bench for load_store_unit with a 32-byte negedge-write,
// combinational-read data memory model. Expected results adapt to whether
// LSU_SUBWORD_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

`ifdef LSU_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.MEM_BYTES(32), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:7];
    assign bus.mem_rdata = mem[bus.mem_address[4:2]];
    always @(negedge clk) begin
        if (bus.mem_write) mem[bus.mem_address[4:2]] <= bus.mem_wdata;
    end

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          reads;
        int          writes;
        logic [31:0] wdata;
        int          accept;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int n_rd = 0;
    int n_wr = 0;
    logic [31:0] last_wd = '0;
    logic overlap = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Monitor: counts strobes and pops/compares on every response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.mem_read) n_rd++;
            if (bus.mem_write) begin
                n_wr++;
                last_wd = bus.mem_wdata;
            end
            if (bus.mem_read && bus.mem_write) overlap = 1'b1;
            if (bus.resp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_resp: got resp_valid=1 required no response");
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
                    check({e.name, "_error"}, 32'(bus.resp_error), 32'(e.err));
                    check({e.name, "_latency"}, 32'(cyc - e.accept + 1), 32'(e.lat));
                    check({e.name, "_reads"}, 32'(n_rd), 32'(e.reads));
                    check({e.name, "_writes"}, 32'(n_wr), 32'(e.writes));
                    if (e.writes > 0) check({e.name, "_wdata"}, last_wd, e.wdata);
                    check({e.name, "_rw_exclusive"}, 32'(overlap), 32'(0));
                end
                n_rd = 0;
                n_wr = 0;
                overlap = 1'b0;
            end
        end
    end

    task automatic issue(input string name, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr, input int elat,
                         input int ereads, input int ewrites, input logic [31:0] ewd);
        exp_t e;
        int waitc = 0;
        @(negedge clk);
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_address  = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        while (!bus.req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.req_ready) begin
            checks++;
            $display("FAIL %s_accept: req_ready=0 after 50 cycles, required 1", name);
            bus.req_valid = 1'b0;
            return;
        end
        e.name   = name;
        e.rdata  = erd;
        e.err    = eerr;
        e.lat    = elat;
        e.reads  = ereads;
        e.writes = ewrites;
        e.wdata  = ewd;
        e.accept = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() > 0 || !bus.req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = SIZE_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_address  = '0;
        bus.req_wdata    = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready",   32'(bus.req_ready),  32'(1));
        check("rst_resp_valid",  32'(bus.resp_valid), 32'(0));
        check("rst_resp_error",  32'(bus.resp_error), 32'(0));
        check("rst_mem_read",    32'(bus.mem_read),   32'(0));
        check("rst_mem_write",   32'(bus.mem_write),  32'(0));
        check("rst_mem_address", bus.mem_address,     32'h0);
        check("rst_mem_wdata",   bus.mem_wdata,       32'h0);
        check("rst_resp_rdata",  bus.resp_rdata,      32'h0);
        rst_n = 1'b1;

        //     name      wr  size       uns  addr   wdata          exp rdata                    err   lat        reads      writes     exp wdata
        issue("st_w08",  1, SIZE_WORD, 0, 32'h08, 32'h11223344, 32'h0,                        0,    2,         0,         1,         32'h11223344);
        issue("ld_w08",  0, SIZE_WORD, 0, 32'h08, 32'h0,        32'h11223344,                 0,    2,         1,         0,         32'h0);
        issue("ld_bu09", 0, SIZE_BYTE, 1, 32'h09, 32'h0,        SUB ? 32'h22 : 32'h0,         !SUB, SUB ? 2:1, SUB ? 1:0, 0,         32'h0);
        issue("st_b0A",  1, SIZE_BYTE, 0, 32'h0A, 32'h000000AB, 32'h0,                        !SUB, SUB ? 3:1, SUB ? 1:0, SUB ? 1:0, 32'h1122AB44);
        issue("ld_w08b", 0, SIZE_WORD, 0, 32'h08, 32'h0,        SUB ? 32'h1122AB44 : 32'h11223344, 0, 2,    1,         0,         32'h0);
        issue("st_b0B",  1, SIZE_BYTE, 0, 32'h0B, 32'h000000F0, 32'h0,                        !SUB, SUB ? 3:1, SUB ? 1:0, SUB ? 1:0, 32'h1122ABF0);
        issue("ld_bs0B", 0, SIZE_BYTE, 0, 32'h0B, 32'h0,        SUB ? 32'hFFFFFFF0 : 32'h0,   !SUB, SUB ? 2:1, SUB ? 1:0, 0,         32'h0);
        issue("ld_hu0A", 0, SIZE_HALF, 1, 32'h0A, 32'h0,        SUB ? 32'h0000ABF0 : 32'h0,   !SUB, SUB ? 2:1, SUB ? 1:0, 0,         32'h0);
        issue("ld_hs0A", 0, SIZE_HALF, 0, 32'h0A, 32'h0,        SUB ? 32'hFFFFABF0 : 32'h0,   !SUB, SUB ? 2:1, SUB ? 1:0, 0,         32'h0);
        issue("st_h08",  1, SIZE_HALF, 0, 32'h08, 32'h1234BEEF, 32'h0,                        !SUB, SUB ? 3:1, SUB ? 1:0, SUB ? 1:0, 32'hBEEFABF0);
        issue("ld_w08c", 0, SIZE_WORD, 0, 32'h08, 32'h0,        SUB ? 32'hBEEFABF0 : 32'h11223344, 0, 2,    1,         0,         32'h0);
        issue("ld_h08",  0, SIZE_HALF, 1, 32'h08, 32'h0,        SUB ? 32'h0000BEEF : 32'h0,   !SUB, SUB ? 2:1, SUB ? 1:0, 0,         32'h0);
        issue("ld_w06",  0, SIZE_WORD, 0, 32'h06, 32'h0,        32'h0,                        1,    1,         0,         0,         32'h0);
        issue("ld_h03",  0, SIZE_HALF, 0, 32'h03, 32'h0,        32'h0,                        1,    1,         0,         0,         32'h0);
        issue("ld_w20",  0, SIZE_WORD, 0, 32'h20, 32'h0,        32'h0,                        1,    1,         0,         0,         32'h0);
        issue("st_w20",  1, SIZE_WORD, 0, 32'h20, 32'h55555555, 32'h0,                        1,    1,         0,         0,         32'h0);
        issue("ld_sz3",  0, 2'b11,     0, 32'h00, 32'h0,        32'h0,                        1,    1,         0,         0,         32'h0);
        issue("st_w1C",  1, SIZE_WORD, 0, 32'h1C, 32'hCAFEF00D, 32'h0,                        0,    2,         0,         1,         32'hCAFEF00D);
        issue("ld_w1C",  0, SIZE_WORD, 0, 32'h1C, 32'h0,        32'hCAFEF00D,                 0,    2,         1,         0,         32'h0);
        issue("ld_hu1E", 0, SIZE_HALF, 1, 32'h1E, 32'h0,        SUB ? 32'h0000F00D : 32'h0,   !SUB, SUB ? 2:1, SUB ? 1:0, 0,         32'h0);
        issue("ld_w00",  0, SIZE_WORD, 0, 32'h00, 32'h0,        32'h0,                        0,    2,         1,         0,         32'h0);
        drain();

        // Reset during WRITE, before the negedge commit.
        begin
            int waitc = 0;
            @(negedge clk);
            bus.req_write   = 1'b1;
            bus.req_size    = SIZE_WORD;
            bus.req_address = 32'h10;
            bus.req_wdata   = 32'hDEADBEEF;
            bus.req_valid   = 1'b1;
            while (!bus.req_ready && waitc < 50) begin
                @(negedge clk);
                waitc++;
            end
            check("rstw_ready_before", 32'(bus.req_ready), 32'(1));
            @(posedge clk);
            #1;
            check("rstw_in_write", 32'(bus.mem_write), 32'(1));
            rst_n = 1'b0;
            bus.req_valid = 1'b0;
            #1;
            check("rstw_write_dropped", 32'(bus.mem_write), 32'(0));
            @(negedge clk);
            #1;
            check("rstw_mem_unchanged", mem[4], 32'h0);
            rst_n = 1'b1;
            @(negedge clk);
            check("rstw_req_ready", 32'(bus.req_ready), 32'(1));
            check("rstw_resp_valid", 32'(bus.resp_valid), 32'(0));
        end

        issue("ld_w10", 0, SIZE_WORD, 0, 32'h10, 32'h0, 32'h0, 0, 2, 1, 0, 32'h0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the CPU data-memory interface: accepts one load/store request from the multicycle controller and sequences the data memory's read/write strobes.
- Handles address alignment, range checks, big-endian byte-lane extraction and sign/zero extension.
- Performs sub-word stores as read-modify-write, since the memory only writes 32-bit words.
- Sits between the controller/ALU result and the data memory; the data memory writes on negedge clk and reads combinationally.

Parameters:
- MEM_BYTES, 32, memory size in bytes; a word access is legal only if its word address <= MEM_BYTES-4.
- ADDR_W, 32, width of the address buses.

Ports:
- clk  in  1  system clock, rising-edge logic.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present; sampled only when req_ready=1.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 zero-extends, 0 sign-extends.
- req_address  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  qualified by resp_valid; misaligned, out of range or illegal size.
- mem_read  out  1  to the memory read enable.
- mem_write  out  1  to the memory write enable.
- mem_address  out  ADDR_W  word-aligned byte address (low two bits always 0).
- mem_wdata  out  32  to the memory write data.
- mem_rdata  in  32  from the memory read data; big-endian, byte at offset 0 is bits 31:24.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - mem_read, mem_write, resp_valid and resp_error = 0.
  - mem_address, mem_wdata and resp_rdata = 0.
  - req_ready=1 once in IDLE.
  - Reset asserted mid-WRITE drops mem_write immediately; if this happens before the negedge, the memory is unchanged.
- All mem_* and resp_* outputs are registered from the rising edge, so they are stable across the memory's negedge write.
- Request acceptance: when IDLE and req_valid=1, latch the request and decode it:
  - Error checks: size 11 is illegal; half requires addr[0]=0; word requires addr[1:0]=00; addr&~3 > MEM_BYTES-4 is out of range.
  - Error → RESP with resp_error=1; no mem strobe is ever raised.
  - Load, or sub-word store → READ.
  - Word store → WRITE.
- READ (1 cycle): mem_read=1, mem_address=addr&~3. Capture mem_rdata at the cycle-ending edge.
  - Load → RESP with resp_rdata set to the extracted, extended lane.
  - Sub-word store → WRITE, with the merged word in mem_wdata.
- Lane rules (big-endian, byte offset o=addr[1:0]):
  - Byte lane = bits [31-8o -: 8].
  - Half lane = bits [31:16] for o=0, [15:0] for o=2.
  - Merge replaces only the addressed lane with req_wdata[7:0] or [15:0].
- WRITE (1 cycle): mem_write=1, mem_address=addr&~3. The memory commits at the mid-cycle negedge. Next state → RESP.
- RESP (1 cycle): resp_valid=1. Next state → IDLE. mem_read and mem_write are 0 in IDLE and RESP.
- Latency from the accept edge to the resp_valid cycle:
  - Error: 1 cycle.
  - Word load or word store: 2 cycles.
  - Sub-word load: 2 cycles.
  - Sub-word store: 3 cycles.
- mem_read and mem_write are never high together.
- req_valid while req_ready=0 is ignored; the controller must hold the request until it is accepted.

Optional Feature:
- Macro: LSU_SUBWORD_EN.
- Defined: byte/half loads are supported, and byte/half stores use read-modify-write as above.
- Undefined: only size 10 is legal; sizes 00, 01 and 11 complete as errors in 1 cycle. The READ→WRITE path and the lane merge logic are removed.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - state encodings IDLE, READ, WRITE, RESP;
  - an alignment-check function.
- One combinational sub-module, lsu_byte_lane: lane extraction with sign/zero extension, and lane merge. It is instantiated only under LSU_SUBWORD_EN for the merge path.

Test Plan:
- Word store 0x11223344 @0x08, then word load @0x08 → mem_write=1 for exactly one cycle; load returns 0x11223344, resp_error=0, 2-cycle latency.
- After the above, unsigned byte load @0x09 → 0x00000022; signed byte load @0x0B after storing 0x000000F0 there → 0xFFFFFFF0.
- Byte store 0xAB @0x0A over word 0x11223344 → READ then WRITE, mem_wdata=0x1122AB44; subsequent word load @0x08 returns 0x1122AB44.
- Misaligned word load @0x06, half load @0x03, out-of-range word @0x20 → resp_error=1 after 1 cycle; mem_read and mem_write stay 0 throughout.
- rst_n pulled low during WRITE before the negedge → mem_write drops immediately and memory contents are unchanged; after release, req_ready=1 and resp_valid=0.
- Build without LSU_SUBWORD_EN, then half load @0x08 → resp_error=1, no memory strobes.
